// File: rtl/fetch_stage.sv
// fetch_stage: IF stage and IF/ID pipeline register for the 5-stage RV32 core.
//
// Generates the PC, keeps at most one request outstanding to instruction
// memory, and registers the returned instruction into IF/ID. It also
// pre-decodes rs1/rs2 for the hazard unit.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               hold IF/ID and PC (from hazard logic)
//   redirect/_pc        taken branch/jump from EX; flushes IF/ID
//   imem_req/addr       request valid / address (addr = pc)
//   imem_gnt            request accepted this cycle
//   imem_rvalid/rdata   one response per granted request
//   if_id_valid/pc/instr IF/ID pipeline register
//   rs1_id/rs2_id       source register fields, 0 when IF/ID holds a bubble
//   stall_count         saturating count of stalled cycles
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic [4:0]      rs1_id,
  output logic [4:0]      rs2_id,
  output logic [31:0]     stall_count
);

  localparam int unsigned     CNT_W   = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    DROP
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   hold_pc_q, hold_pc_d;
  logic [31:0]       hold_instr_q, hold_instr_d;
  logic              ifid_valid_d;
  logic [XLEN-1:0]   ifid_pc_d;
  logic [31:0]       ifid_instr_d;
  logic [CNT_W-1:0]  stall_count_d;
  logic              deliver;
  logic [XLEN-1:0]   deliver_pc;
  logic [31:0]       deliver_instr;

  // Request only from FETCH; a redirect this cycle would fetch a stale PC.
  assign imem_req  = (state_q == FETCH) & ~redirect & ~rst;
  assign imem_addr = pc_q;

  // State register and all pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      hold_pc_q    <= '0;
      hold_instr_q <= NOP_INSTR;
      if_id_valid  <= 1'b0;
      if_id_pc     <= '0;
      if_id_instr  <= NOP_INSTR;
      rs1_id       <= '0;
      rs2_id       <= '0;
      stall_count  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      if_id_valid  <= ifid_valid_d;
      if_id_pc     <= ifid_pc_d;
      if_id_instr  <= ifid_instr_d;
      // Register fields are decoded from the next IF/ID value so they line up.
      rs1_id       <= ifid_valid_d ? ifid_instr_d[19:15] : 5'd0;
      rs2_id       <= ifid_valid_d ? ifid_instr_d[24:20] : 5'd0;
      stall_count  <= stall_count_d;
    end
  end

  // Next-state, PC, hold buffer and IF/ID update.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_pc_d     = hold_pc_q;
    hold_instr_d  = hold_instr_q;
    deliver       = 1'b0;
    deliver_pc    = pc_q;
    deliver_instr = imem_rdata;
    ifid_valid_d  = if_id_valid;
    ifid_pc_d     = if_id_pc;
    ifid_instr_d  = if_id_instr;
    stall_count_d = stall_count;

    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          // A response still in flight must be swallowed in DROP.
          pc_d    = redirect_pc;
          state_d = imem_rvalid ? FETCH : DROP;
        end else if (imem_rvalid) begin
          if (stall) begin
            hold_pc_d    = pc_q;
            hold_instr_d = imem_rdata;
            state_d      = HOLD;
          end else begin
            deliver = 1'b1;
            pc_d    = pc_q + PC_STEP;
            state_d = FETCH;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = FETCH;
        end else if (!stall) begin
          deliver       = 1'b1;
          deliver_pc    = hold_pc_q;
          deliver_instr = hold_instr_q;
          pc_d          = pc_q + PC_STEP;
          state_d       = FETCH;
        end
      end
      DROP: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (imem_rvalid) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    // Redirect flushes even under stall; stall holds; otherwise load or bubble.
    if (redirect || (!stall && !deliver)) begin
      ifid_valid_d = 1'b0;
      ifid_pc_d    = '0;
      ifid_instr_d = NOP_INSTR;
    end else if (!stall) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = deliver_pc;
      ifid_instr_d = deliver_instr;
    end

    if (stall && (stall_count != '1)) begin
      stall_count_d = stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios followed by randomized traffic, all
// checked each cycle against a transaction-level model of the fetch stage
// and an instruction memory with random grant and response latency.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic [31:0] stall_count;

  int checks   = 0;
  int failures = 0;

  // Memory model
  logic        mem_busy = 1'b0;
  int          mem_delay = 0;
  logic [31:0] mem_addr = '0;
  logic        mem_fixed = 1'b1;
  logic [31:0] mem_fixed_val = 32'h0050_0093;

  // Reference model: request outstanding, its response to be discarded,
  // a stalled response parked, current PC, and the IF/ID contents.
  logic [31:0] m_pc   = '0;
  logic        m_busy = 1'b0;
  logic        m_drop = 1'b0;
  logic        m_held = 1'b0;
  logic [31:0] m_hpc  = '0;
  logic [31:0] m_hins = '0;
  logic        m_v    = 1'b0;
  logic [31:0] m_ipc  = '0;
  logic [31:0] m_ins  = 32'h13;
  logic [31:0] m_sc   = '0;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_fixed ? mem_fixed_val : ((a * 32'h9E37_79B1) ^ 32'h1234_5678);
  endfunction

  // One clock cycle: drive inputs, check combinational request, advance the
  // models, then check registered outputs after the edge.
  task automatic step(input logic s, input logic r, input logic [31:0] rpc,
                      input logic g, input logic rs, input int lat);
    logic        rv;
    logic        mreq;
    logic [31:0] rd;
    logic        dlv;
    logic [31:0] dpc;
    logic [31:0] dins;
    rv = mem_busy && (mem_delay == 0) && !rs;
    rd = rv ? mem_word(mem_addr) : $urandom;
    rst = rs; stall = s; redirect = r; redirect_pc = rpc;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    #1;
    mreq = !m_busy && !m_held && !r && !rs;
    check("imem_req", 32'(imem_req), 32'(mreq));
    if (!rs) check("imem_addr", imem_addr, m_pc);

    if (rs) begin
      mem_busy = 1'b0;
    end else begin
      if (rv) mem_busy = 1'b0;
      else if (mem_busy) mem_delay--;
      if (mreq && g) begin
        mem_busy = 1'b1; mem_addr = m_pc; mem_delay = lat;
      end
    end

    if (rs) begin
      m_pc = '0; m_busy = 0; m_drop = 0; m_held = 0;
      m_v = 0; m_ipc = '0; m_ins = 32'h13; m_sc = '0;
    end else begin
      if (s && m_sc != 32'hFFFF_FFFF) m_sc++;
      dlv = 0; dpc = m_pc; dins = rd;
      if (m_held) begin
        if (r) begin
          m_held = 0; m_pc = rpc;
        end else if (!s) begin
          dlv = 1; dpc = m_hpc; dins = m_hins; m_held = 0; m_pc = m_pc + 4;
        end
      end else if (m_busy) begin
        if (rv) begin
          m_busy = 0;
          if (m_drop || r) begin
            m_drop = 0;
            if (r) m_pc = rpc;
          end else if (s) begin
            m_held = 1; m_hpc = m_pc; m_hins = rd;
          end else begin
            dlv = 1; m_pc = m_pc + 4;
          end
        end else if (r) begin
          m_drop = 1; m_pc = rpc;
        end
      end else begin
        if (r) m_pc = rpc;
        else if (g) m_busy = 1;
      end
      if (r || (!s && !dlv)) begin
        m_v = 0; m_ipc = '0; m_ins = 32'h13;
      end else if (!s) begin
        m_v = 1; m_ipc = dpc; m_ins = dins;
      end
    end

    @(negedge clk);
    check("if_id_valid", 32'(if_id_valid), 32'(m_v));
    check("if_id_pc", if_id_pc, m_ipc);
    check("if_id_instr", if_id_instr, m_ins);
    check("rs1_id", 32'(rs1_id), 32'(m_v ? m_ins[19:15] : 5'd0));
    check("rs2_id", 32'(rs2_id), 32'(m_v ? m_ins[24:20] : 5'd0));
    check("stall_count", stall_count, m_sc);
  endtask

  initial begin
    logic        s, r, g, rs;
    logic [31:0] rpc;
    int          lat;

    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check("rst_if_id_instr", if_id_instr, 32'h0000_0013);
    check("rst_stall_count", stall_count, 32'd0);

    // First fetch: grant at once, response next cycle.
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("t1_valid", 32'(if_id_valid), 32'd1);
    check("t1_pc", if_id_pc, 32'h0);
    check("t1_instr", if_id_instr, 32'h0050_0093);
    check("t1_rs1", 32'(rs1_id), 32'd0);
    check("t1_rs2", 32'(rs2_id), 32'd5);
    check("t1_next_addr", imem_addr, 32'h4);

    // Stall in the response cycle, held three cycles.
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("stall_hold_pc", if_id_pc, 32'h0);
    check("stall_no_req", 32'(imem_req), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    check("stall_release_pc", if_id_pc, 32'h4);
    check("stall_count3", stall_count, 32'd3);

    // Redirect while waiting; late response must be dropped.
    step(0, 0, 0, 1, 0, 2);
    step(0, 1, 32'h100, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("drop_valid", 32'(if_id_valid), 32'd0);
    check("drop_addr", imem_addr, 32'h100);

    // Redirect beats stall with a valid IF/ID.
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("rs_pre_valid", 32'(if_id_valid), 32'd1);
    step(1, 1, 32'h200, 0, 0, 0);
    check("rs_flush_valid", 32'(if_id_valid), 32'd0);
    check("rs_flush_instr", if_id_instr, 32'h0000_0013);
    check("rs_addr", imem_addr, 32'h200);

    // Grant withheld: request and address stay steady.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    check("nognt_req", 32'(imem_req), 32'd1);
    check("nognt_addr", imem_addr, 32'h200);

    // PC wrap.
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0);

    // Reset while waiting.
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    check("rstw_valid", 32'(if_id_valid), 32'd0);
    check("rstw_addr", imem_addr, 32'h0);
    check("rstw_req", 32'(imem_req), 32'd0);
    check("rstw_count", stall_count, 32'd0);

    // Randomized traffic.
    mem_fixed = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      s   = ($urandom_range(99) < 30);
      r   = ($urandom_range(99) < 10);
      g   = ($urandom_range(99) < 60);
      rs  = ($urandom_range(199) == 0);
      lat = $urandom_range(3);
      rpc = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : {$urandom_range(32'hFFFF) , 16'h0} | 32'($urandom_range(255) * 4);
      step(s, r, rpc, g, rs, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
